// File: rtl/dmm_pkg.sv
// dmm_pkg: shared register offsets, target enum and address decode for data_mem_manager.
package dmm_pkg;
  localparam logic [31:0] FIFO_DATA = 32'd0;
  localparam logic [31:0] STATUS    = 32'd1;
  localparam logic [31:0] CYCLES    = 32'd2;
  localparam logic [31:0] ERR       = 32'd3;
  localparam int ERR_OVF   = 0;
  localparam int ERR_UNMAP = 1;
  typedef enum logic [2:0] {T_RAM, T_FIFO, T_STATUS, T_CYCLES, T_ERR, T_UNMAPPED} target_t;
  function automatic target_t decode(input logic [31:0] a, input logic [31:0] base, input int aw);
    return (a >> aw) == 32'd0 ? T_RAM :
           a == base + FIFO_DATA ? T_FIFO :
           a == base + STATUS ? T_STATUS :
           a == base + CYCLES ? T_CYCLES :
           a == base + ERR ? T_ERR : T_UNMAPPED;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: 2^AW-deep word FIFO; head reads 0 while empty so reset presents a zero word.
module stream_fifo #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [31:0]   head
);
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full  = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign head  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/data_mem_manager.sv
// data_mem_manager: CPU data-memory decode to RAM, output stream FIFO and status/timer registers.
// Optional DMM_BYTE_MODE_EN adds byte-lane RAM access via byte_mode_i/byte_lane_i.
module data_mem_manager
  import dmm_pkg::*;
#(
  parameter int          RAM_AW  = 8,
  parameter int          FIFO_AW = 3,
  parameter logic [31:0] IO_BASE = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic        wren_i,
`ifdef DMM_BYTE_MODE_EN
  input  logic        byte_mode_i,
  input  logic [1:0]  byte_lane_i,
`endif
  output logic [31:0] data_o,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        err_o
);
  target_t            tgt;
  logic [31:0]        mem [2**RAM_AW];
  logic [31:0]        ram_word, ram_rd, cycles, status;
  logic [1:0]         err_q, err_set, err_clr;
  logic               full, empty, push, pop;
  logic [FIFO_AW:0]   count;
  logic [RAM_AW-1:0]  idx;
  assign tgt      = decode(address_i, IO_BASE, RAM_AW);
  assign idx      = address_i[RAM_AW-1:0];
  assign ram_word = mem[idx];
  assign pop      = out_valid_o & out_ready_i;
  assign push     = wren_i & (tgt == T_FIFO) & (!full | pop);
  assign status   = 32'({count, 6'b0, empty, full});
  assign out_valid_o = !empty;
  assign err_o    = |err_q;
`ifdef DMM_BYTE_MODE_EN
  assign ram_rd = byte_mode_i ? {24'b0, ram_word[byte_lane_i*8 +: 8]} : ram_word;
  always_ff @(posedge CLK)
    if (wren_i && tgt == T_RAM) begin
      if (byte_mode_i) mem[idx][byte_lane_i*8 +: 8] <= data_i[7:0];
      else mem[idx] <= data_i;
    end
`else
  assign ram_rd = ram_word;
  always_ff @(posedge CLK)
    if (wren_i && tgt == T_RAM) mem[idx] <= data_i;
`endif
  assign data_o = tgt == T_RAM    ? ram_rd :
                  tgt == T_STATUS ? status :
                  tgt == T_CYCLES ? cycles :
                  tgt == T_ERR    ? {30'b0, err_q} : '0;
  // A new error event on a bit overrides a same-cycle clear of that bit.
  always_comb begin
    err_clr = (wren_i && tgt == T_ERR) ? data_i[1:0] : 2'b0;
    err_set = '0;
    err_set[ERR_OVF]   = wren_i && tgt == T_FIFO && full && !pop;
    err_set[ERR_UNMAP] = wren_i && tgt == T_UNMAPPED;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cycles <= '0;
      err_q  <= '0;
    end else begin
      cycles <= (wren_i && tgt == T_CYCLES) ? data_i : cycles + 32'd1;
      err_q  <= (err_q & ~err_clr) | err_set;
    end
  stream_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .pop   (pop),
    .din   (data_i),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (out_data_o)
  );
endmodule

// File: tb/tb_data_mem_manager.sv
// tb_data_mem_manager: directed and random checks against a queue/array reference model.
module tb_data_mem_manager;
  localparam logic [31:0] IOB = 32'h0001_0000;
  logic        CLK = 0, RST = 0, wren_i = 0, out_ready_i = 0;
  logic [31:0] address_i = 0, data_i = 0;
  logic [31:0] data_o, out_data_o;
  logic        out_valid_o, err_o;
  int total = 0, bad = 0;
  logic [31:0] ram [256];
  bit          known [256];
  logic [31:0] q [$];
  logic [31:0] cyc_m;
  logic [1:0]  err_m;

  data_mem_manager dut (
    .CLK(CLK), .RST(RST), .address_i(address_i), .data_i(data_i), .wren_i(wren_i),
    .data_o(data_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ready_i(out_ready_i), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit unmapped(input logic [31:0] a);
    return a >= 256 && !(a >= IOB && a <= IOB + 3);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int n = q.size();
    if (a < 256) return ram[a[7:0]];
    if (a == IOB + 1) return (n << 8) | (n == 0 ? 2 : 0) | (n == 8 ? 1 : 0);
    if (a == IOB + 2) return cyc_m;
    if (a == IOB + 3) return {30'b0, err_m};
    return 0;
  endfunction

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                     input string tag = "", input bit use_k = 0, input logic [31:0] k = 0);
    bit pop, ovf;
    logic [1:0] clr;
    address_i = a; data_i = d; wren_i = w; out_ready_i = r;
    #1;
    if (a >= 256 || known[a[7:0]]) chk("rd", data_o, model_rd(a));
    chk("valid", {31'b0, out_valid_o}, {31'b0, q.size() != 0});
    chk("head", out_data_o, q.size() != 0 ? q[0] : 32'd0);
    chk("err_o", {31'b0, err_o}, {31'b0, err_m != 0});
    if (use_k) chk(tag, data_o, k);
    @(posedge CLK);
    pop = q.size() != 0 && r;
    ovf = 0;
    if (pop) void'(q.pop_front());
    if (w && a == IOB) begin
      if (q.size() < 8) q.push_back(d);
      else ovf = 1;
    end
    clr = (w && a == IOB + 3) ? d[1:0] : 2'b0;
    err_m = (err_m & ~clr) | {w && unmapped(a), ovf};
    cyc_m = (w && a == IOB + 2) ? d : cyc_m + 1;
    if (w && a < 256) begin ram[a[7:0]] = d; known[a[7:0]] = 1; end
    @(negedge CLK);
  endtask

  task automatic rst_pulse();
    wren_i = 0; out_ready_i = 0;
    #2 RST = 0;
    #1 chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_err_o", {31'b0, err_o}, 32'd0);
    #1 RST = 1;
    q.delete(); err_m = 0; cyc_m = 0;
    @(negedge CLK);
    cyc_m = 1;
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_valid", {31'b0, out_valid_o}, 32'd0);
    chk("reset_data", out_data_o, 32'd0);
    chk("reset_err", {31'b0, err_o}, 32'd0);
    address_i = IOB + 1; #1 chk("reset_status", data_o, 32'h2);
    address_i = IOB + 2; #1 chk("reset_cycles", data_o, 32'h0);
    address_i = IOB + 3; #1 chk("reset_errreg", data_o, 32'h0);
    @(negedge CLK);
    RST = 1; cyc_m = 0; err_m = 0;
    // RAM write/read and same-cycle old value
    cyc(5, 32'h1111_1111, 1, 0);
    cyc(5, 32'hDEAD_BEEF, 1, 0, "ram_same_cycle", 1, 32'h1111_1111);
    cyc(5, 0, 0, 0, "ram_read", 1, 32'hDEAD_BEEF);
    // fill FIFO, overflow, clear
    for (int i = 1; i <= 8; i++) cyc(IOB, i, 1, 0);
    cyc(IOB + 1, 0, 0, 0, "status_full", 1, 32'h801);
    cyc(IOB, 99, 1, 0);
    chk("ovf_err_o", {31'b0, err_o}, 32'd1);
    cyc(IOB + 3, 0, 0, 0, "err_ovf", 1, 32'h1);
    cyc(IOB + 3, 1, 1, 0);
    // push while full with simultaneous pop
    cyc(IOB, 9, 1, 1);
    cyc(IOB + 1, 0, 0, 0, "status_pushpop", 1, 32'h801);
    for (int i = 2; i <= 9; i++) begin
      chk("drain", out_data_o, i);
      cyc(0, 0, 0, 1);
    end
    cyc(IOB + 1, 0, 0, 0, "status_drained", 1, 32'h2);
    // cycle counter wrap
    cyc(IOB + 2, 32'hFFFF_FFFE, 1, 0);
    cyc(IOB + 2, 0, 0, 0, "cyc0", 1, 32'hFFFF_FFFE);
    cyc(IOB + 2, 0, 0, 0, "cyc1", 1, 32'hFFFF_FFFF);
    cyc(IOB + 2, 0, 0, 0, "cyc2", 1, 32'h0);
    // unmapped write
    cyc(0, 32'hCAFE_0000, 1, 0);
    cyc(32'h0002_0000, 32'h5555_5555, 1, 0);
    cyc(0, 0, 0, 0, "ram_unchanged", 1, 32'hCAFE_0000);
    cyc(IOB + 3, 0, 0, 0, "err_unmap", 1, 32'h2);
    cyc(IOB + 3, 2, 1, 0);
    cyc(IOB + 3, 0, 0, 0, "err_cleared", 1, 32'h0);
    chk("err_o_cleared", {31'b0, err_o}, 32'd0);
    // async reset mid-transfer
    for (int i = 0; i < 3; i++) cyc(IOB, 32'hA0 + i, 1, 0);
    rst_pulse();
    cyc(IOB + 1, 0, 0, 0, "status_after_rst", 1, 32'h2);
    // random traffic
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      a = sel < 3 ? $urandom_range(0, 15) :
          sel < 6 ? IOB :
          sel < 9 ? IOB + $urandom_range(1, 3) : 32'h0000_0100 + $urandom_range(0, 3);
      cyc(a, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
